// File: rtl/lc3_writeback.sv
// LC-3 write-back stage: W_Control source mux, 8 x 16-bit register file with
// asynchronous dual read, and N/Z/P condition codes updated on each commit.
// Optional feature: define LC3_WB_BYPASS_EN to forward DR_in onto a read port
// whose source index matches dr during a commit cycle.
module lc3_writeback #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] memout,
  input  logic [2:0]        dr,
  input  logic [2:0]        sr1,
  input  logic [2:0]        sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr
);

  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] dr_in;

  // Condition codes of a committed value, interpreted as two's complement.
  function automatic logic [2:0] cond_codes(input logic signed [DATA_W-1:0] value);
    if (value < 0)
      return 3'b100;
    else if (value == '0)
      return 3'b010;
    else
      return 3'b001;
  endfunction

  // Select the write-back source every cycle.
  always_comb begin
    dr_in = aluout;
    case (W_Control)
      2'd0:    dr_in = aluout;
      2'd1:    dr_in = pcout;
      2'd2:    dr_in = npc;
      default: dr_in = memout;
    endcase
  end

  // Commit DR_in to R[dr] and refresh the condition codes; reset clears all.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      psr <= 3'b000;
    end else if (enable_writeback) begin
      regs[dr] <= dr_in;
      psr      <= cond_codes(dr_in);
    end
  end

  // Asynchronous source reads; registers are already zero while reset is low,
  // and the forwarding path is gated by reset so it cannot leak data then.
  always_comb begin
`ifdef LC3_WB_BYPASS_EN
    VSR1 = (reset && enable_writeback && (sr1 == dr)) ? dr_in : regs[sr1];
    VSR2 = (reset && enable_writeback && (sr2 == dr)) ? dr_in : regs[sr2];
`else
    VSR1 = regs[sr1];
    VSR2 = regs[sr2];
`endif
  end

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: directed scenarios plus randomized
// traffic compared against a behavioural register-file model.
module tb_lc3_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_writeback = 1'b0;
  logic [1:0]  W_Control = 2'd0;
  logic [15:0] aluout = '0, pcout = '0, npc = '0, memout = '0;
  logic [2:0]  dr = '0, sr1 = '0, sr2 = '0;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  psr;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [15:0] m_r [8];
  logic [2:0]  m_psr;

  lc3_writeback dut (
    .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
    .W_Control(W_Control), .aluout(aluout), .pcout(pcout), .npc(npc),
    .memout(memout), .dr(dr), .sr1(sr1), .sr2(sr2),
    .VSR1(VSR1), .VSR2(VSR2), .psr(psr)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_src();
    logic [15:0] srcs [4];
    srcs[0] = aluout; srcs[1] = pcout; srcs[2] = npc; srcs[3] = memout;
    return srcs[W_Control];
  endfunction

  function automatic logic [2:0] m_cc(input logic [15:0] v);
    int unsigned u;
    u = v;
    if (u >= 32768) return 3'b100;
    if (u == 0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] idx);
    if (!reset) return 16'h0000;
`ifdef LC3_WB_BYPASS_EN
    if (enable_writeback && idx == dr) return m_src();
`endif
    return m_r[idx];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_psr = 3'b000;
  endtask

  // Drive one transaction at the falling edge; unselected sources get noise.
  task automatic apply(input logic [1:0] wc, input logic [2:0] d,
                       input logic [15:0] val, input logic en);
    @(negedge clock);
    aluout = 16'($urandom); pcout = 16'($urandom);
    npc    = 16'($urandom); memout = 16'($urandom);
    case (wc)
      2'd0: aluout = val;
      2'd1: pcout  = val;
      2'd2: npc    = val;
      default: memout = val;
    endcase
    W_Control = wc;
    dr = d;
    enable_writeback = en;
  endtask

  // Advance one rising edge and mirror the commit in the model.
  task automatic step();
    @(posedge clock);
    if (reset && enable_writeback) begin
      m_r[dr] = m_src();
      m_psr   = m_cc(m_src());
    end
    #1;
  endtask

  task automatic test_reset();
    m_clear();
    #2;
    checks++; if (VSR1 !== 16'h0000) begin errors++; $display("FAIL reset_vsr1: got %h want 0000", VSR1); end
    checks++; if (VSR2 !== 16'h0000) begin errors++; $display("FAIL reset_vsr2: got %h want 0000", VSR2); end
    checks++; if (psr !== 3'b000) begin errors++; $display("FAIL reset_psr: got %b want 000", psr); end
    @(negedge clock);
    reset = 1'b1;
    apply(2'd0, 3'd3, 16'h1234, 1'b1);
    sr1 = 3'd3;
    step();
    @(negedge clock);
    enable_writeback = 1'b0;
    #1;
    checks++; if (VSR1 !== 16'h1234) begin errors++; $display("FAIL reset_pre_r3: got %h want 1234", VSR1); end
    #1;
    reset = 1'b0;
    m_clear();
    #1;
    checks++; if (VSR1 !== 16'h0000) begin errors++; $display("FAIL reset_async_vsr1: got %h want 0000", VSR1); end
    checks++; if (psr !== 3'b000) begin errors++; $display("FAIL reset_async_psr: got %b want 000", psr); end
    // Commit attempted while reset is held: must be ignored.
    apply(2'd0, 3'd3, 16'h5555, 1'b1);
    sr1 = 3'd3; sr2 = 3'd3;
    #1;
    checks++; if (VSR2 !== 16'h0000) begin errors++; $display("FAIL reset_no_bypass: got %h want 0000", VSR2); end
    step();
    checks++; if (VSR1 !== 16'h0000) begin errors++; $display("FAIL reset_commit_ignored: got %h want 0000", VSR1); end
    checks++; if (psr !== 3'b000) begin errors++; $display("FAIL reset_commit_psr: got %b want 000", psr); end
    @(negedge clock);
    enable_writeback = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (VSR1 !== 16'h0000) begin errors++; $display("FAIL reset_release_r3: got %h want 0000", VSR1); end
  endtask

  task automatic test_commit_neg();
    apply(2'd0, 3'd2, 16'h8001, 1'b1);
    sr1 = 3'd2;
    step();
    checks++; if (VSR1 !== 16'h8001) begin errors++; $display("FAIL commit_neg_vsr1: got %h want 8001", VSR1); end
    checks++; if (psr !== 3'b100) begin errors++; $display("FAIL commit_neg_psr: got %b want 100", psr); end
  endtask

  task automatic test_zero_pos();
    apply(2'd3, 3'd5, 16'h0000, 1'b1);
    step();
    checks++; if (psr !== 3'b010) begin errors++; $display("FAIL zero_psr: got %b want 010", psr); end
    apply(2'd2, 3'd5, 16'h3001, 1'b1);
    sr2 = 3'd5;
    step();
    checks++; if (VSR2 !== 16'h3001) begin errors++; $display("FAIL pos_vsr2: got %h want 3001", VSR2); end
    checks++; if (psr !== 3'b001) begin errors++; $display("FAIL pos_psr: got %b want 001", psr); end
  endtask

  task automatic test_hold();
    apply(2'd0, 3'd2, 16'hFFFF, 1'b0);
    sr1 = 3'd2;
    repeat (10) step();
    checks++; if (VSR1 !== 16'h8001) begin errors++; $display("FAIL hold_r2: got %h want 8001", VSR1); end
    checks++; if (psr !== 3'b001) begin errors++; $display("FAIL hold_psr: got %b want 001", psr); end
  endtask

  task automatic test_read_during_write();
    logic [15:0] exp_pre;
    apply(2'd0, 3'd4, 16'h0011, 1'b1);
    step();
    apply(2'd1, 3'd4, 16'h00AA, 1'b1);
    sr1 = 3'd4;
    #1;
`ifdef LC3_WB_BYPASS_EN
    exp_pre = 16'h00AA;
`else
    exp_pre = 16'h0011;
`endif
    checks++; if (VSR1 !== exp_pre) begin errors++; $display("FAIL rdw_pre_edge: got %h want %h", VSR1, exp_pre); end
    checks++; if (psr !== 3'b001) begin errors++; $display("FAIL rdw_psr_pre_edge: got %b want 001", psr); end
    step();
    checks++; if (VSR1 !== 16'h00AA) begin errors++; $display("FAIL rdw_post_edge: got %h want 00aa", VSR1); end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) begin
      apply(2'(i % 4), 3'(i), 16'h1000 + 16'(i), 1'b1);
      step();
    end
    @(negedge clock);
    enable_writeback = 1'b0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        @(negedge clock);
        sr1 = 3'(a); sr2 = 3'(b);
        #1;
        checks++; if (VSR1 !== 16'h1000 + 16'(a)) begin errors++; $display("FAIL sweep_vsr1[%0d,%0d]: got %h want %h", a, b, VSR1, 16'h1000 + 16'(a)); end
        checks++; if (VSR2 !== 16'h1000 + 16'(b)) begin errors++; $display("FAIL sweep_vsr2[%0d,%0d]: got %h want %h", a, b, VSR2, 16'h1000 + 16'(b)); end
      end
    end
    for (int i = 0; i < 8; i++) m_r[i] = 16'h1000 + 16'(i);
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 200; n++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 7) == 0) v = 16'h0000;
      apply(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), v, 1'($urandom_range(0, 3) != 0));
      sr1 = 3'($urandom_range(0, 7));
      sr2 = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom_range(0, 7));
      #1;
      checks++; if (VSR1 !== m_read(sr1)) begin errors++; $display("FAIL rand_pre_vsr1[%0d]: got %h want %h", n, VSR1, m_read(sr1)); end
      checks++; if (VSR2 !== m_read(sr2)) begin errors++; $display("FAIL rand_pre_vsr2[%0d]: got %h want %h", n, VSR2, m_read(sr2)); end
      step();
      checks++; if (psr !== m_psr) begin errors++; $display("FAIL rand_psr[%0d]: got %b want %b", n, psr, m_psr); end
      checks++; if (VSR1 !== m_read(sr1)) begin errors++; $display("FAIL rand_post_vsr1[%0d]: got %h want %h", n, VSR1, m_read(sr1)); end
      checks++; if (VSR2 !== m_read(sr2)) begin errors++; $display("FAIL rand_post_vsr2[%0d]: got %h want %h", n, VSR2, m_read(sr2)); end
    end
  endtask

  initial begin
    test_reset();
    test_commit_neg();
    test_zero_pos();
    test_hold();
    test_read_during_write();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
